// File: rtl/rf64_arbiter_if.sv
// rf64_arbiter_if: two-requester command/handshake bundle plus shared read-back bus.
interface rf64_arbiter_if;
   logic        m0_req;
   logic        m0_wr;
   logic [1:0]  m0_addr;
   logic [63:0] m0_wdata;
   logic        m0_done;
   logic        m1_req;
   logic        m1_wr;
   logic [1:0]  m1_addr;
   logic [63:0] m1_wdata;
   logic        m1_done;
   logic [63:0] rdata;
   logic        rid;
   logic        busy;

   modport master (
      output m0_req, m0_wr, m0_addr, m0_wdata,
      output m1_req, m1_wr, m1_addr, m1_wdata,
      input  m0_done, m1_done, rdata, rid, busy
   );

   modport slave (
      input  m0_req, m0_wr, m0_addr, m0_wdata,
      input  m1_req, m1_wr, m1_addr, m1_wdata,
      output m0_done, m1_done, rdata, rid, busy
   );
endinterface

// File: rtl/rf64_arbiter.sv
// rf64_arbiter: round-robin arbiter giving two masters one read/write at a time to four 64-bit registers.
module rf64_arbiter #(
   parameter int DATA_W  = 64,
   parameter int N_ENTRY = 4
) (
   input logic            clk,
   input logic            reset_n,
   rf64_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

   state_t              state;
   logic                rr;
   logic                pick;
   logic                cmd_id;
   logic                cmd_wr;
   logic [1:0]          cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;
   logic [DATA_W-1:0]   regs [N_ENTRY];
   logic [N_ENTRY-1:0]  en;

   // A lone requester wins outright; rr only breaks ties.
   always_comb pick = (bus.m0_req && bus.m1_req) ? rr : bus.m1_req;

   always_comb begin
      en = '0;
      for (int i = 0; i < N_ENTRY; i++)
         en[i] = (state == GRANT) && cmd_wr && (cmd_addr == 2'(i));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_ENTRY; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < N_ENTRY; i++) if (en[i]) regs[i] <= cmd_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         rr          <= 1'b0;
         cmd_id      <= 1'b0;
         cmd_wr      <= 1'b0;
         cmd_addr    <= '0;
         cmd_wdata   <= '0;
         bus.rdata   <= '0;
         bus.rid     <= 1'b0;
         bus.m0_done <= 1'b0;
         bus.m1_done <= 1'b0;
         bus.busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.m0_req || bus.m1_req) begin
               cmd_id    <= pick;
               cmd_wr    <= pick ? bus.m1_wr    : bus.m0_wr;
               cmd_addr  <= pick ? bus.m1_addr  : bus.m0_addr;
               cmd_wdata <= pick ? bus.m1_wdata : bus.m0_wdata;
               bus.busy  <= 1'b1;
               state     <= GRANT;
            end
            GRANT: begin
               if (!cmd_wr) bus.rdata <= regs[cmd_addr];
               bus.rid     <= cmd_id;
               bus.m0_done <= !cmd_id;
               bus.m1_done <= cmd_id;
               rr          <= !cmd_id;
               state       <= DONE;
            end
            DONE: begin
               bus.m0_done <= 1'b0;
               bus.m1_done <= 1'b0;
               bus.busy    <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rf64_arbiter.sv
// tb_rf64_arbiter: directed scenario checks of the rf64_arbiter handshake, storage and round-robin.
module tb_rf64_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   vectors = 0;
   int   errors = 0;

   rf64_arbiter_if bus ();
   rf64_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   int          lat;
   logic [63:0] rd;
   logic        r_id;
   logic        p_id  [2];
   logic [63:0] p_rd  [2];
   logic        p_rid [2];
   int          p_got;

   task automatic idle_inputs();
      bus.m0_req = 0; bus.m0_wr = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
      bus.m1_req = 0; bus.m1_wr = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      reset_n = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      @(negedge clk);
   endtask

   // Drives one transaction; lat counts edges from request to done (10 = timed out).
   task automatic txn(input logic id, input logic wr, input logic [1:0] addr, input logic [63:0] wd);
      @(negedge clk);
      if (id) begin bus.m1_req = 1; bus.m1_wr = wr; bus.m1_addr = addr; bus.m1_wdata = wd; end
      else    begin bus.m0_req = 1; bus.m0_wr = wr; bus.m0_addr = addr; bus.m0_wdata = wd; end
      lat = 0;
      while (lat < 10) begin
         @(posedge clk); #1; lat++;
         if (id ? bus.m1_done : bus.m0_done) break;
      end
      rd = bus.rdata;
      r_id = bus.rid;
      if (id) bus.m1_req = 0; else bus.m0_req = 0;
      @(negedge clk);
   endtask

   // Both masters read at once; winners and their read results are recorded in order.
   task automatic pair_read(input logic [1:0] a0, input logic [1:0] a1);
      @(negedge clk);
      bus.m0_req = 1; bus.m0_wr = 0; bus.m0_addr = a0;
      bus.m1_req = 1; bus.m1_wr = 0; bus.m1_addr = a1;
      p_got = 0;
      for (int c = 0; c < 20 && p_got < 2; c++) begin
         @(posedge clk); #1;
         if (bus.m0_done || bus.m1_done) begin
            p_id[p_got] = bus.m1_done; p_rd[p_got] = bus.rdata; p_rid[p_got] = bus.rid;
            if (bus.m1_done) bus.m1_req = 0; else bus.m0_req = 0;
            p_got++;
         end
      end
      bus.m0_req = 0; bus.m1_req = 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.m0_req = 1'($urandom); bus.m0_wr = 1'($urandom); bus.m0_addr = 2'($urandom);
         bus.m0_wdata = {$urandom, $urandom};
         bus.m1_req = 1'($urandom); bus.m1_wr = 1'($urandom); bus.m1_addr = 2'($urandom);
         bus.m1_wdata = {$urandom, $urandom};
         @(posedge clk); #1;
         vectors++;
         if ({bus.m0_done, bus.m1_done, bus.busy, bus.rid} !== 4'b0 || bus.rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_hold: done0=%b done1=%b busy=%b rid=%b rdata=%h, required all 0",
                     bus.m0_done, bus.m1_done, bus.busy, bus.rid, bus.rdata);
         end
      end
      @(negedge clk);
      idle_inputs();
      reset_n = 1;
      @(posedge clk); #1;
      vectors++;
      if (bus.busy !== 1'b0 || bus.m0_done !== 1'b0 || bus.m1_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: busy=%b done0=%b done1=%b, required 0", bus.busy, bus.m0_done, bus.m1_done);
      end
      for (int a = 0; a < 4; a++) begin
         txn(0, 0, 2'(a), 64'd0);
         vectors++;
         if (rd !== 64'd0 || lat != 2) begin
            errors++;
            $display("FAIL reset_readback[%0d]: rdata=%h lat=%0d, required 0 and 2", a, rd, lat);
         end
      end
   endtask

   task automatic test_single();
      txn(0, 1, 2'd2, 64'h0123_4567_89AB_CDEF);
      vectors++;
      if (lat != 2) begin
         errors++;
         $display("FAIL write_latency: %0d edges, required 2", lat);
      end
      txn(0, 0, 2'd2, 64'd0);
      vectors++;
      if (rd !== 64'h0123_4567_89AB_CDEF || r_id !== 1'b0 || lat != 2) begin
         errors++;
         $display("FAIL read_back: rdata=%h rid=%b lat=%0d, required 0123456789abcdef 0 2", rd, r_id, lat);
      end
      txn(0, 0, 2'd1, 64'd0);
      vectors++;
      if (rd !== 64'd0) begin
         errors++;
         $display("FAIL read_unwritten: rdata=%h, required 0", rd);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.m0_req = 1; bus.m0_wr = 1; bus.m0_addr = 0; bus.m0_wdata = 64'hDEAD;
      @(posedge clk); #1;
      vectors++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_grant_busy: busy=%b, required 1", bus.busy);
      end
      reset_n = 0;
      #1;
      vectors++;
      if (bus.busy !== 1'b0 || bus.m0_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_async_reset: busy=%b done0=%b, required 0 0", bus.busy, bus.m0_done);
      end
      @(negedge clk);
      bus.m0_req = 0;
      @(negedge clk);
      reset_n = 1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (bus.m0_done !== 1'b0 || bus.m1_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done: done0=%b done1=%b, required 0 0", bus.m0_done, bus.m1_done);
         end
      end
      txn(0, 0, 2'd0, 64'd0);
      vectors++;
      if (rd !== 64'd0 || lat != 2) begin
         errors++;
         $display("FAIL mid_discard: rdata=%h lat=%0d, required 0 and 2", rd, lat);
      end
   endtask

   task automatic test_round_robin();
      int seq [4];
      int at  [4];
      int n = 0;
      int overlap = 0;
      @(negedge clk);
      bus.m0_req = 1; bus.m0_wr = 1; bus.m0_addr = 0; bus.m0_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
      bus.m1_req = 1; bus.m1_wr = 1; bus.m1_addr = 1; bus.m1_wdata = 64'h5555_5555_5555_5555;
      for (int c = 0; c < 30 && n < 4; c++) begin
         @(posedge clk); #1;
         if (bus.m0_done && bus.m1_done) overlap++;
         if (bus.m0_done || bus.m1_done) begin
            seq[n] = bus.m1_done ? 1 : 0; at[n] = c; n++;
         end
      end
      bus.m0_req = 0; bus.m1_req = 0;
      @(negedge clk);
      vectors++;
      if (n != 4 || overlap != 0) begin
         errors++;
         $display("FAIL rr_count: %0d grants %0d overlaps, required 4 and 0", n, overlap);
      end
      for (int k = 0; k < n; k++) begin
         vectors++;
         if (seq[k] != k % 2) begin
            errors++;
            $display("FAIL rr_order[%0d]: m%0d served, required m%0d", k, seq[k], k % 2);
         end
         if (k > 0) begin
            vectors++;
            if (at[k] - at[k-1] != 3) begin
               errors++;
               $display("FAIL rr_spacing[%0d]: %0d cycles, required 3", k, at[k] - at[k-1]);
            end
         end
      end
   endtask

   task automatic test_priority_flip();
      for (int k = 0; k < 2; k++) begin
         txn(k == 0, 0, 2'(k == 0 ? 1 : 0), 64'd0);
         vectors++;
         if (rd !== (k == 0 ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA) || r_id !== (k == 0)) begin
            errors++;
            $display("FAIL solo_read[%0d]: rdata=%h rid=%b", k, rd, r_id);
         end
         pair_read(2'd0, 2'd1);
         vectors++;
         if (p_got != 2 || p_id[0] !== (k != 0) || p_id[1] !== (k == 0)) begin
            errors++;
            $display("FAIL flip_order[%0d]: got=%0d first=m%0d, required 2 and m%0d", k, p_got, p_id[0], k != 0);
         end
         for (int j = 0; j < p_got; j++) begin
            vectors++;
            if (p_rid[j] !== p_id[j] ||
                p_rd[j] !== (p_id[j] ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA)) begin
               errors++;
               $display("FAIL flip_data[%0d][%0d]: rid=%b rdata=%h for m%0d", k, j, p_rid[j], p_rd[j], p_id[j]);
            end
         end
      end
   endtask

   task automatic test_write_isolation();
      logic [63:0] exp [4];
      exp[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      exp[1] = 64'h5555_5555_5555_5555;
      exp[2] = 64'h0123_4567_89AB_CDEF;
      exp[3] = 64'hFFFF_FFFF_FFFF_FFFF;
      txn(0, 1, 2'd2, exp[2]);
      txn(0, 0, 2'd2, 64'd0);
      txn(1, 1, 2'd3, exp[3]);
      vectors++;
      if (rd !== exp[2] || r_id !== 1'b1 || lat != 2) begin
         errors++;
         $display("FAIL rdata_hold_on_write: rdata=%h rid=%b lat=%0d, required %h 1 2", rd, r_id, lat, exp[2]);
      end
      for (int a = 0; a < 4; a++) begin
         txn(1, 0, 2'(a), 64'd0);
         vectors++;
         if (rd !== exp[a] || r_id !== 1'b1) begin
            errors++;
            $display("FAIL isolation[%0d]: rdata=%h rid=%b, required %h 1", a, rd, r_id, exp[a]);
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_reset_mid();
      apply_reset();
      test_round_robin();
      test_priority_flip();
      test_write_isolation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
